rr_arbiter4: RTL and testbench
==============================

Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter that shares one downstream resource between requesters.
- Grants are one-hot, in the same format as the 2-to-4 decode path, with a binary grant index alongside.
- The enable input gates all arbitration.
- A programmable maximum hold time prevents one requester from starving the others.

Parameters:
- MAX_HOLD, default 8: maximum consecutive grant cycles for one holder while other requests are pending. Legal range 1..255.

Ports:
- clk     input   1  system clock; all state updates on its rising edge.
- rst     input   1  synchronous reset, active-high.
- en      input   1  arbitration enable; 0 forces gnt to zero and the FSM to IDLE.
- req     input   4  request vector; req[k]=1 means requester k wants the resource.
- gnt     output  4  registered one-hot grant, or 0000 when idle.
- gnt_id  output  2  binary index of the current holder; valid only while gnt_vld=1.
- gnt_vld output  1  1 while any grant bit is set.

Behaviour:
- Clocking: one clock and one reset. Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - gnt=0000, gnt_id=00, gnt_vld=0.
  - State IDLE, priority pointer ptr=0, hold counter cnt=0.
  - Reset has priority over every other input, including mid-grant.
- Internal state:
  - ptr (2 bits): the requester with highest priority at the next arbitration.
  - cnt (8 bits): cycles the current holder has held the grant; saturates at MAX_HOLD.
- Winner selection: the first k with req[k]=1, searching ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - Every new grant sets ptr = winner+1 mod 4. Wrap 3->0 is required.
- IDLE state:
  - If en=1 and req!=0000: next cycle gnt=onehot(winner), gnt_id=winner, gnt_vld=1, cnt=1, go to GRANT.
  - Otherwise stay in IDLE with outputs zero.
- GRANT state, holder h = gnt_id. Conditions are evaluated in this priority order:
  1. en=0: next cycle outputs are zero, go to IDLE. ptr is unchanged.
  2. Release (req[h]=0):
     - If other requests are pending, re-arbitrate among them next cycle with no idle gap: new one-hot grant, cnt=1.
     - If none are pending, go to IDLE with outputs zero.
  3. Timeout (cnt==MAX_HOLD and any req[j]=1 for j!=h): forced rotation next cycle to the first pending requester after h. cnt=1.
  4. Otherwise keep the grant. cnt increments, saturating at MAX_HOLD.
- A lone requester holds indefinitely. Timeout never drops a grant when nobody else is waiting.
- Release and timeout in the same cycle are handled as release; the result is identical.
- Latency: request to first grant is 1 cycle. Handoff between holders is 1 cycle. en deassert to gnt=0000 is 1 cycle.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_vld equals OR of gnt.
  - gnt_id matches the position of the set gnt bit whenever gnt_vld=1.
- Requests may change at any cycle. Requests are sampled only on clock edges; no combinational path from req to gnt.

Test Plan:
1. Hold rst=1 with en=1, req=1111 for 3 cycles: gnt=0000, gnt_vld=0. Release rst with req=0001: one cycle later gnt=0001, gnt_id=0, gnt_vld=1.
2. MAX_HOLD=4, en=1, req=1111 held constant: gnt is 0001 for 4 cycles, then 0010 x4, 0100 x4, 1000 x4, then back to 0001. No zero cycles between grants.
3. req=0100 only, held 20 cycles: gnt=0100 continuously, no drop at cnt==MAX_HOLD. Deassert req: gnt=0000 next cycle, state IDLE.
4. Holder 0 drops req[0] while req=1010: next cycle gnt=0010, gnt_id=1. Then with ptr=2, drop req[1] with req=1000: next cycle gnt=1000.
5. Mid-grant (gnt=0100), drive en=0: gnt=0000 next cycle. Raise en=1 with req=1111: gnt=1000, because ptr=3 was preserved.
6. Mid-grant (gnt=1000, cnt=3), pulse rst for one cycle: outputs zero next cycle. Then req=1010: gnt=0010, since ptr was reset to 0 and req[0]=0.

Source files
------------

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-requester round-robin arbiter with bounded hold time
//
// Shares one downstream resource among four requesters. A rotating priority
// pointer gives fairness. A hold counter forces a handoff once the current
// holder has kept the grant for MAX_HOLD cycles while someone else is waiting.
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - synchronous reset, active-high
//   en      - arbitration enable; low drops any grant and idles the arbiter
//   req     - request vector, req[k]=1 means requester k wants the resource
//   gnt     - registered one-hot grant, 0000 when idle
//   gnt_id  - binary index of the holder, meaningful while gnt_vld=1
//   gnt_vld - 1 while a grant is active
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_vld
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    state_t     state;
    logic [1:0] ptr;
    logic [7:0] cnt;

    logic [3:0] cand;
    logic       found;
    logic [1:0] win;

    // Candidates for the next grant. While granting, the holder is removed so
    // that a timeout rotates to someone else. On release req[holder] is
    // already 0, so the same mask serves both cases.
    always_comb begin
        cand = req;
        if (state == GRANT) begin
            cand = req & ~gnt;
        end
    end

    // Rotating priority search starting at ptr. ptr always sits at
    // holder+1 during a grant, so this also finds "first pending after h".
    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!found && cand[ptr + 2'(i)]) begin
                found = 1'b1;
                win   = ptr + 2'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            cnt     <= 8'd0;
            gnt     <= 4'b0000;
            gnt_id  <= 2'd0;
            gnt_vld <= 1'b0;
        end else if (!en) begin
            // ptr is deliberately kept so fairness resumes where it left off
            state   <= IDLE;
            cnt     <= 8'd0;
            gnt     <= 4'b0000;
            gnt_vld <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state   <= GRANT;
                        gnt     <= 4'b0001 << win;
                        gnt_id  <= win;
                        gnt_vld <= 1'b1;
                        ptr     <= win + 2'd1;
                        cnt     <= 8'd1;
                    end
                end
                GRANT: begin
                    if (!req[gnt_id] || (cnt == HOLD_MAX && found)) begin
                        // Release or timeout: hand off without an idle gap
                        // when anyone else is waiting.
                        if (found) begin
                            gnt    <= 4'b0001 << win;
                            gnt_id <= win;
                            ptr    <= win + 2'd1;
                            cnt    <= 8'd1;
                        end else begin
                            state   <= IDLE;
                            gnt     <= 4'b0000;
                            gnt_vld <= 1'b0;
                            cnt     <= 8'd0;
                        end
                    end else if (cnt != HOLD_MAX) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    gnt     <= 4'b0000;
                    gnt_vld <= 1'b0;
                    cnt     <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb/tb_rr_arbiter4.sv - scoreboard bench for rr_arbiter4 with MAX_HOLD=4
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_vld;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         at;
        logic [3:0] g;
    } exp_t;

    exp_t sbq[$];

    rr_arbiter4 #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Apply inputs just after a rising edge; the expected outputs appear
    // after the following rising edge.
    task automatic drive(input logic r, input logic e, input logic [3:0] q,
                         input logic [3:0] exp_g);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r;
        en  = e;
        req = q;
        x.at = cyc + 1;
        x.g  = exp_g;
        sbq.push_back(x);
    endtask

    // Monitor: compares outputs mid-cycle against the scoreboard entry due now
    always @(negedge clk) begin
        exp_t e;
        total++;
        if (gnt_vld !== (|gnt)) begin
            bad++;
            $display("FAIL vld_inv cyc=%0d gnt=%b gnt_vld=%b", cyc, gnt, gnt_vld);
        end
        if (sbq.size() > 0 && sbq[0].at == cyc) begin
            e = sbq.pop_front();
            total++;
            if (gnt !== e.g) begin
                bad++;
                $display("FAIL gnt cyc=%0d got=%b want=%b", cyc, gnt, e.g);
            end
            total++;
            if (gnt_vld !== (|e.g)) begin
                bad++;
                $display("FAIL gnt_vld cyc=%0d got=%b want=%b", cyc, gnt_vld, |e.g);
            end
            if (|e.g) begin
                total++;
                if (gnt_id !== idx_of(e.g)) begin
                    bad++;
                    $display("FAIL gnt_id cyc=%0d got=%0d want=%0d", cyc, gnt_id, idx_of(e.g));
                end
            end
        end
    end

    initial begin
        // 1: reset dominates active requests, then first grant in one cycle
        repeat (3) drive(1'b1, 1'b1, 4'b1111, 4'b0000);
        drive(1'b0, 1'b1, 4'b0001, 4'b0001);

        // 2: full contention, four-cycle rotation with wrap 3->0
        drive(1'b1, 1'b0, 4'b0000, 4'b0000);
        for (int i = 0; i < 18; i++) begin
            logic [3:0] one;
            one = 4'b0001;
            drive(1'b0, 1'b1, 4'b1111, one << ((i / 4) % 4));
        end

        // 3: lone requester holds past MAX_HOLD, then drops to idle
        repeat (20) drive(1'b0, 1'b1, 4'b0100, 4'b0100);
        drive(1'b0, 1'b1, 4'b0000, 4'b0000);

        // 4: release handoffs (ptr=3 here, so req=0001 picks 0)
        drive(1'b0, 1'b1, 4'b0001, 4'b0001);
        drive(1'b0, 1'b1, 4'b1010, 4'b0010);
        drive(1'b0, 1'b1, 4'b1000, 4'b1000);

        // 5: en drop mid-grant keeps ptr=3
        drive(1'b0, 1'b1, 4'b0100, 4'b0100);
        drive(1'b0, 1'b0, 4'b1111, 4'b0000);
        drive(1'b0, 1'b0, 4'b1111, 4'b0000);
        drive(1'b0, 1'b1, 4'b1111, 4'b1000);

        // 6: reset mid-grant at cnt=3 clears ptr
        drive(1'b0, 1'b1, 4'b1000, 4'b1000);
        drive(1'b0, 1'b1, 4'b1000, 4'b1000);
        drive(1'b1, 1'b1, 4'b1000, 4'b0000);
        drive(1'b0, 1'b1, 4'b1010, 4'b0010);

        // release coinciding with timeout: holder 1 at cnt=4 drops, 3 waiting
        drive(1'b0, 1'b1, 4'b1010, 4'b0010);
        drive(1'b0, 1'b1, 4'b1010, 4'b0010);
        drive(1'b0, 1'b1, 4'b1010, 4'b0010);
        drive(1'b0, 1'b1, 4'b1000, 4'b1000);
        drive(1'b0, 1'b1, 4'b0000, 4'b0000);

        begin
            int guard;
            guard = 0;
            while (sbq.size() > 0 && guard < 10) begin
                @(posedge clk);
                guard++;
            end
            @(posedge clk);
            if (sbq.size() > 0) begin
                total++;
                bad++;
                $display("FAIL drain left=%0d", sbq.size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
